// File: rtl/comperator_axi_ip_v1_0_frame_sync.sv
// ---------------------------------------------------------------------------
// comperator_axi_ip_v1_0_frame_sync
//
// Passive frame-synchronisation monitor for NUM_CH AXI4-Stream video
// channels. Once armed with 'go' it watches for the start-of-frame beat
// (tuser) on every channel. It reports which channels have delivered their
// SOF, how many cycles separate the first and last SOF, and whether any
// channel repeated its SOF before all channels lined up. The block only
// observes the streams and never drives any handshake signal.
//
// Optional feature macro: FRAME_SYNC_LINE_CNT_EN
//   defined   -> per-channel line counters (tlast beats since that channel's SOF)
//   undefined -> no counter logic, line_cnt is tied to zero
//
// Ports
//   aclk           clock
//   aresetn        synchronous active-low reset
//   s_axis_tdata   NUM_CH*DATA_WIDTH pixel data (observed only)
//   s_axis_tvalid  per-channel valid
//   s_axis_tready  per-channel ready from the downstream sink
//   s_axis_tuser   per-channel start-of-frame marker
//   s_axis_tlast   per-channel end-of-line marker
//   go             arm / re-arm request
//   cont           continuous mode: re-arm automatically after one locked cycle
//   sof_seen       channel delivered its SOF since arming
//   sof            level, all channels synchronised
//   sof_pulse      one-cycle pulse on entry to the locked state
//   skew           cycles between first and last channel SOF (saturating)
//   sync_err       sticky: a channel repeated its SOF before lock
//   line_cnt       per-channel line counters, CNT_WIDTH bits each
// ---------------------------------------------------------------------------
module comperator_axi_ip_v1_0_frame_sync #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]           s_axis_tvalid,
  input  logic [NUM_CH-1:0]           s_axis_tready,
  input  logic [NUM_CH-1:0]           s_axis_tuser,
  input  logic [NUM_CH-1:0]           s_axis_tlast,
  input  logic                        go,
  input  logic                        cont,
  output logic [NUM_CH-1:0]           sof_seen,
  output logic                        sof,
  output logic                        sof_pulse,
  output logic [CNT_WIDTH-1:0]        skew,
  output logic                        sync_err,
  output logic [NUM_CH*CNT_WIDTH-1:0] line_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, PARTIAL, LOCKED} state_t;

  localparam logic [NUM_CH-1:0] ALL_CH = '1;

  state_t                 state_q, state_d;
  logic [NUM_CH-1:0]      seen_q, seen_d;
  logic [CNT_WIDTH-1:0]   skew_q, skew_d;
  logic                   err_q, err_d;
  logic                   pulse_q, pulse_d;

  logic [NUM_CH-1:0]      beat;
  logic [NUM_CH-1:0]      sof_beat;
  logic                   restart;
  logic                   collide;
  logic [NUM_CH-1:0]      cand_seen;

  // Pixel data is only carried through for observation; tlast is unused
  // when the line counters are compiled out.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tdata, s_axis_tlast};

  assign beat     = s_axis_tvalid & s_axis_tready;
  assign sof_beat = beat & s_axis_tuser;

  // A go while waiting for SOFs restarts the search; same-cycle SOFs then
  // count against the fresh (cleared) set. A repeated SOF while partially
  // synchronised also restarts, keeping only the channels that fired now.
  assign restart   = go && (state_q == ARMED || state_q == PARTIAL);
  assign collide   = !go && (state_q == PARTIAL) && |(sof_beat & seen_q);
  assign cand_seen = (restart || collide) ? sof_beat : (seen_q | sof_beat);

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go) state_d = ARMED;
      end
      ARMED, PARTIAL: begin
        if (cand_seen == ALL_CH) state_d = LOCKED;
        else if (|cand_seen)     state_d = PARTIAL;
        else                     state_d = ARMED;
      end
      LOCKED: begin
        if (go || cont) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    seen_d  = seen_q;
    skew_d  = skew_q;
    err_d   = err_q;
    pulse_d = (state_d == LOCKED) && (state_q != LOCKED);
    case (state_q)
      IDLE: begin
        if (go) begin
          seen_d = '0;
          skew_d = '0;
          err_d  = 1'b0;
        end
      end
      ARMED: begin
        seen_d = cand_seen;
        skew_d = '0;
      end
      PARTIAL: begin
        seen_d = cand_seen;
        if (restart || collide)  skew_d = '0;
        else if (skew_q != '1)   skew_d = skew_q + CNT_WIDTH'(1);
        if (collide) err_d = 1'b1;
      end
      LOCKED: begin
        if (go || cont) begin
          seen_d = '0;
          skew_d = '0;
        end
      end
      default: begin
        seen_d = '0;
        skew_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      seen_q  <= '0;
      skew_q  <= '0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      seen_q  <= seen_d;
      skew_q  <= skew_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
    end
  end

  assign sof_seen  = seen_q;
  assign sof       = (state_q == LOCKED);
  assign sof_pulse = pulse_q;
  assign skew      = skew_q;
  assign sync_err  = err_q;

`ifdef FRAME_SYNC_LINE_CNT_EN
  // Line counters run in every state; an SOF beat restarts the count and
  // its own tlast (if any) is the first line.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_line
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        cnt_q <= '0;
      end else if (sof_beat[c]) begin
        cnt_q <= s_axis_tlast[c] ? CNT_WIDTH'(1) : '0;
      end else if (beat[c] && s_axis_tlast[c] && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
    assign line_cnt[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`else
  assign line_cnt = '0;
`endif

endmodule

// File: tb/tb_comperator_axi_ip_v1_0_frame_sync.sv
// ---------------------------------------------------------------------------
// tb_comperator_axi_ip_v1_0_frame_sync
//
// Directed bench for the two-channel default configuration. Each step drives
// one cycle of stimulus, pushes the outputs expected after that clock edge
// onto a scoreboard queue, and pops/compares them once the edge has passed.
// Line counter expectations follow FRAME_SYNC_LINE_CNT_EN.
// ---------------------------------------------------------------------------
module tb_comperator_axi_ip_v1_0_frame_sync;

  localparam int DW = 24;
  localparam int NC = 2;
  localparam int CW = 12;

`ifdef FRAME_SYNC_LINE_CNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  typedef struct {
    string          tag;
    logic           sof;
    logic           pulse;
    logic [NC-1:0]  seen;
    logic [CW-1:0]  skew;
    logic           err;
    bit             chk_line;
    logic [NC*CW-1:0] line;
  } exp_t;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic [NC*DW-1:0]   s_axis_tdata = '0;
  logic [NC-1:0]      s_axis_tvalid = '0;
  logic [NC-1:0]      s_axis_tready = '0;
  logic [NC-1:0]      s_axis_tuser = '0;
  logic [NC-1:0]      s_axis_tlast = '0;
  logic               go = 1'b0;
  logic               cont = 1'b0;
  logic [NC-1:0]      sof_seen;
  logic               sof;
  logic               sof_pulse;
  logic [CW-1:0]      skew;
  logic               sync_err;
  logic [NC*CW-1:0]   line_cnt;

  exp_t scoreboard[$];
  int   errors = 0;
  int   checks = 0;

  comperator_axi_ip_v1_0_frame_sync #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .go(go), .cont(cont),
    .sof_seen(sof_seen), .sof(sof), .sof_pulse(sof_pulse), .skew(skew),
    .sync_err(sync_err), .line_cnt(line_cnt)
  );

  always #5 aclk = ~aclk;

  // Expected line_cnt with channel 1 idle at zero and channel 0 at 'ch0'.
  function automatic logic [NC*CW-1:0] lineExp(input int ch0);
    logic [NC*CW-1:0] v;
    v = '0;
    if (LC_EN) v[CW-1:0] = CW'(ch0);
    return v;
  endfunction

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (scoreboard.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed 0 entries expected 1");
    end
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checks++;
      assert (sof === e.sof) else begin
        errors++;
        $error("[TB] FAIL %s.sof observed %0b expected %0b", e.tag, sof, e.sof);
      end
      checks++;
      assert (sof_pulse === e.pulse) else begin
        errors++;
        $error("[TB] FAIL %s.sof_pulse observed %0b expected %0b", e.tag, sof_pulse, e.pulse);
      end
      checks++;
      assert (sof_seen === e.seen) else begin
        errors++;
        $error("[TB] FAIL %s.sof_seen observed %b expected %b", e.tag, sof_seen, e.seen);
      end
      checks++;
      assert (skew === e.skew) else begin
        errors++;
        $error("[TB] FAIL %s.skew observed %0d expected %0d", e.tag, skew, e.skew);
      end
      checks++;
      assert (sync_err === e.err) else begin
        errors++;
        $error("[TB] FAIL %s.sync_err observed %0b expected %0b", e.tag, sync_err, e.err);
      end
      if (e.chk_line) begin
        checks++;
        assert (line_cnt === e.line) else begin
          errors++;
          $error("[TB] FAIL %s.line_cnt observed %h expected %h", e.tag, line_cnt, e.line);
        end
      end
    end
  endtask

  // Drive one cycle, record what must be visible after the edge, then check.
  task automatic applyStimulus(
    input string tag, input logic rst_n, input logic go_i, input logic cont_i,
    input logic [NC-1:0] v, input logic [NC-1:0] r, input logic [NC-1:0] u,
    input logic [NC-1:0] l, input logic e_sof, input logic e_pulse,
    input logic [NC-1:0] e_seen, input int e_skew, input logic e_err,
    input bit chk_line, input logic [NC*CW-1:0] e_line);
    exp_t e;
    @(negedge aclk);
    aresetn       = rst_n;
    go            = go_i;
    cont          = cont_i;
    s_axis_tvalid = v;
    s_axis_tready = r;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tdata  = {$urandom, $urandom};
    e.tag = tag; e.sof = e_sof; e.pulse = e_pulse; e.seen = e_seen;
    e.skew = CW'(e_skew); e.err = e_err; e.chk_line = chk_line; e.line = e_line;
    scoreboard.push_back(e);
    @(posedge aclk);
    #1;
    checkOutput();
  endtask

  initial begin
    $display("[TB] frame_sync bench start, line counters %0s", LC_EN ? "on" : "off");
    // Reset state
    applyStimulus("reset0", 0,0,0, 2'b11,2'b11,2'b00,2'b00, 0,0,2'b00,0,0, 1,'0);
    applyStimulus("reset1", 0,0,0, 2'b11,2'b11,2'b11,2'b00, 0,0,2'b00,0,0, 1,'0);
    // SOFs ignored until go
    applyStimulus("idle_sof", 1,0,0, 2'b11,2'b11,2'b11,2'b00, 0,0,2'b00,0,0, 0,'0);
    applyStimulus("go_idle", 1,1,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b00,0,0, 0,'0);
    // Aligned SOFs lock immediately
    applyStimulus("aligned", 1,0,0, 2'b11,2'b11,2'b11,2'b00, 1,1,2'b11,0,0, 0,'0);
    applyStimulus("aligned_hold", 1,0,0, 2'b00,2'b11,2'b00,2'b00, 1,0,2'b11,0,0, 0,'0);
    // Skew of five cycles
    applyStimulus("rearm_a", 1,1,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b00,0,0, 0,'0);
    applyStimulus("skew_ch0", 1,0,0, 2'b01,2'b11,2'b01,2'b00, 0,0,2'b01,0,0, 0,'0);
    for (int i = 1; i <= 4; i++)
      applyStimulus("skew_wait", 1,0,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b01,i,0, 0,'0);
    applyStimulus("skew_ch1", 1,0,0, 2'b10,2'b11,2'b10,2'b00, 1,1,2'b11,5,0, 0,'0);
    applyStimulus("skew_hold", 1,0,0, 2'b00,2'b11,2'b00,2'b00, 1,0,2'b11,5,0, 0,'0);
    // Repeated SOF before lock
    applyStimulus("rearm_b", 1,1,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b00,0,0, 0,'0);
    applyStimulus("rep_ch0", 1,0,0, 2'b01,2'b11,2'b01,2'b00, 0,0,2'b01,0,0, 0,'0);
    applyStimulus("rep_wait", 1,0,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b01,1,0, 0,'0);
    applyStimulus("rep_again", 1,0,0, 2'b01,2'b11,2'b01,2'b00, 0,0,2'b01,0,1, 0,'0);
    applyStimulus("rep_wait2", 1,0,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b01,1,1, 0,'0);
    applyStimulus("rep_ch1", 1,0,0, 2'b10,2'b11,2'b10,2'b00, 1,1,2'b11,2,1, 0,'0);
    // go in LOCKED keeps sync_err
    applyStimulus("go_locked", 1,1,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b00,0,1, 0,'0);
    // SOF without ready is not a beat
    applyStimulus("noready", 1,0,0, 2'b10,2'b01,2'b10,2'b00, 0,0,2'b00,0,1, 0,'0);
    applyStimulus("ready_ch1", 1,0,0, 2'b10,2'b11,2'b10,2'b00, 0,0,2'b10,0,1, 0,'0);
    // go in PARTIAL with a same-cycle SOF
    applyStimulus("go_partial", 1,1,0, 2'b01,2'b11,2'b01,2'b00, 0,0,2'b01,0,1, 0,'0);
    applyStimulus("gp_ch1", 1,0,0, 2'b10,2'b11,2'b10,2'b00, 1,1,2'b11,1,1, 0,'0);
    // Reset clears sticky error
    applyStimulus("reset2", 0,0,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b00,0,0, 1,'0);
    applyStimulus("go_idle2", 1,1,0, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b00,0,0, 0,'0);
    // Continuous mode, three aligned frames, go held low
    for (int f = 0; f < 3; f++) begin
      applyStimulus("cont_frame", 1,0,1, 2'b11,2'b11,2'b11,2'b00, 1,1,2'b11,0,0, 0,'0);
      applyStimulus("cont_rearm", 1,0,1, 2'b00,2'b11,2'b00,2'b00, 0,0,2'b00,0,0, 0,'0);
    end
    // Line counting on channel 0, then reset mid-frame
    applyStimulus("line_sof", 1,0,0, 2'b01,2'b11,2'b01,2'b00, 0,0,2'b01,0,0, 1,lineExp(0));
    for (int i = 1; i <= 7; i++)
      applyStimulus("line_beat", 1,0,0, 2'b01,2'b11,2'b00,2'b01, 0,0,2'b01,i,0, 1,lineExp(i));
    applyStimulus("reset_mid", 0,0,0, 2'b01,2'b11,2'b00,2'b01, 0,0,2'b00,0,0, 1,'0);
    applyStimulus("post_reset", 1,0,0, 2'b11,2'b11,2'b11,2'b00, 0,0,2'b00,0,0, 0,'0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
